// File: rtl/load_queue_ooo.sv
// Out-of-order load queue: dual in-order allocate, AGU address capture, oldest-ready issue,
// in-order retire and partial flush. Optional LQ_ISSUE_BYPASS_EN offers an AGU address in its writeback cycle.
module load_queue_ooo #(
    parameter int LQ_DEPTH = 8,
    parameter int LQ_SEL   = $clog2(LQ_DEPTH),
    parameter int ROB_W    = 6,
    parameter int REG_W    = 6,
    parameter int IMM_W    = 32,
    parameter int ADDR_W   = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_disp_valid_1,
    input  logic              i_disp_valid_2,
    input  logic [ROB_W-1:0]  i_disp_rob_idx_1,
    input  logic [ROB_W-1:0]  i_disp_rob_idx_2,
    input  logic [REG_W-1:0]  i_disp_base_reg_1,
    input  logic [REG_W-1:0]  i_disp_base_reg_2,
    input  logic [IMM_W-1:0]  i_disp_offset_1,
    input  logic [IMM_W-1:0]  i_disp_offset_2,
    output logic              o_disp_ready,
    output logic [LQ_SEL:0]   o_disp_ptr_1,
    output logic [LQ_SEL:0]   o_disp_ptr_2,
    input  logic              i_agu_valid,
    input  logic [LQ_SEL:0]   i_agu_ptr,
    input  logic [ADDR_W-1:0] i_agu_addr,
    output logic              o_issue_valid,
    input  logic              i_issue_ready,
    output logic [LQ_SEL:0]   o_issue_ptr,
    output logic [ADDR_W-1:0] o_issue_addr,
    output logic [ROB_W-1:0]  o_issue_rob_idx,
    input  logic [1:0]        i_commit_cnt,
    input  logic              i_flush_valid,
    input  logic [LQ_SEL:0]   i_flush_ptr,
    output logic              o_lq_full,
    output logic              o_lq_empty,
    output logic [LQ_SEL:0]   o_lq_count
);
    localparam int PW = LQ_SEL + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(LQ_DEPTH);

    logic [PW-1:0]       r_head, r_tail;
    logic [LQ_DEPTH-1:0] r_valid, r_addr_rdy, r_issued, r_wrap;
    logic [ROB_W-1:0]    r_rob  [LQ_DEPTH];
    logic [REG_W-1:0]    r_base [LQ_DEPTH];
    logic [IMM_W-1:0]    r_off  [LQ_DEPTH];
    logic [ADDR_W-1:0]   r_addr [LQ_DEPTH];
    logic                r_hold;
    logic [LQ_SEL-1:0]   r_hold_idx;

    logic [PW-1:0]       w_count, w_alloc;
    logic                w_disp_fire, w_agu_live, w_scan_hit, w_hold_ok;
    logic                w_issue_valid, w_issue_fire, w_bypass;
    logic [LQ_SEL-1:0]   w_head_idx, w_tail_idx, w_way2_idx, w_agu_idx, w_scan_idx, w_sel_idx;
    logic [LQ_DEPTH-1:0] w_flush_kill;
    logic                w_unused_fields;

    assign w_count      = r_tail - r_head;
    assign o_lq_count   = w_count;
    assign o_lq_full    = (w_count == DEPTH_P);
    assign o_lq_empty   = (w_count == '0);
    assign o_disp_ready = (w_count <= DEPTH_P - PW'(2));
    assign w_disp_fire  = o_disp_ready & ~i_flush_valid;
    assign w_alloc      = w_disp_fire ? PW'(i_disp_valid_1) + PW'(i_disp_valid_2) : '0;
    assign o_disp_ptr_1 = r_tail;
    assign o_disp_ptr_2 = i_disp_valid_1 ? r_tail + PW'(1) : r_tail;

    assign w_head_idx = r_head[LQ_SEL-1:0];
    assign w_tail_idx = r_tail[LQ_SEL-1:0];
    assign w_way2_idx = o_disp_ptr_2[LQ_SEL-1:0];
    assign w_agu_idx  = i_agu_ptr[LQ_SEL-1:0];
    // A writeback only lands if the slot is live and still belongs to the same lap of the ring.
    assign w_agu_live = i_agu_valid & r_valid[w_agu_idx] & (r_wrap[w_agu_idx] == i_agu_ptr[LQ_SEL]);

    always_comb begin
        logic [LQ_SEL-1:0] v_idx;
        w_scan_hit = 1'b0;
        w_scan_idx = '0;
        v_idx      = '0;
        for (int k = LQ_DEPTH - 1; k >= 0; k--) begin
            v_idx = w_head_idx + LQ_SEL'(k);
            if (r_valid[v_idx] && r_addr_rdy[v_idx] && !r_issued[v_idx]) begin
                w_scan_hit = 1'b1;
                w_scan_idx = v_idx;
            end
        end
    end

    // An offer refused by the cache stays pinned so issue_* cannot change under a stalled handshake.
    assign w_hold_ok = r_hold & r_valid[r_hold_idx] & r_addr_rdy[r_hold_idx] & ~r_issued[r_hold_idx];

    always_comb begin
        w_issue_valid = 1'b0;
        w_bypass      = 1'b0;
        w_sel_idx     = '0;
        if (w_hold_ok) begin
            w_issue_valid = 1'b1;
            w_sel_idx     = r_hold_idx;
        end else if (w_scan_hit) begin
            w_issue_valid = 1'b1;
            w_sel_idx     = w_scan_idx;
        end
`ifdef LQ_ISSUE_BYPASS_EN
        else if (w_agu_live && !r_issued[w_agu_idx]) begin
            w_issue_valid = 1'b1;
            w_bypass      = 1'b1;
            w_sel_idx     = w_agu_idx;
        end
`endif
    end

    assign w_issue_fire    = w_issue_valid & i_issue_ready;
    assign o_issue_valid   = w_issue_valid;
    assign o_issue_ptr     = w_issue_valid ? {r_wrap[w_sel_idx], w_sel_idx} : '0;
    assign o_issue_addr    = !w_issue_valid ? '0 : (w_bypass ? i_agu_addr : r_addr[w_sel_idx]);
    assign o_issue_rob_idx = w_issue_valid ? r_rob[w_sel_idx] : '0;

    always_comb begin
        logic [PW-1:0] v_ptr;
        w_flush_kill = '0;
        v_ptr        = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            v_ptr = {r_wrap[i], LQ_SEL'(i)};
            w_flush_kill[i] = i_flush_valid & r_valid[i] &
                              ((v_ptr - i_flush_ptr) < (r_tail - i_flush_ptr));
        end
    end

    // Base register and offset are held for debug visibility; nothing in this block consumes them.
    always_comb begin
        w_unused_fields = 1'b0;
        for (int i = 0; i < LQ_DEPTH; i++)
            w_unused_fields = w_unused_fields ^ (^r_base[i]) ^ (^r_off[i]);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_valid    <= '0;
            r_addr_rdy <= '0;
            r_issued   <= '0;
            r_wrap     <= '0;
            r_hold     <= 1'b0;
            r_hold_idx <= '0;
            for (int i = 0; i < LQ_DEPTH; i++) begin
                r_rob[i]  <= '0;
                r_base[i] <= '0;
                r_off[i]  <= '0;
                r_addr[i] <= '0;
            end
        end else begin
            if (i_commit_cnt != 2'd0)
                r_valid[w_head_idx] <= 1'b0;
            if (i_commit_cnt[1])
                r_valid[w_head_idx + LQ_SEL'(1)] <= 1'b0;
            if (w_agu_live) begin
                r_addr[w_agu_idx]     <= i_agu_addr;
                r_addr_rdy[w_agu_idx] <= 1'b1;
            end
            if (w_issue_fire) begin
                r_issued[w_sel_idx]   <= 1'b1;
                r_addr_rdy[w_sel_idx] <= 1'b1;
            end
            for (int i = 0; i < LQ_DEPTH; i++) begin
                if (w_flush_kill[i]) begin
                    r_valid[i]    <= 1'b0;
                    r_addr_rdy[i] <= 1'b0;
                    r_issued[i]   <= 1'b0;
                end
            end
            if (w_disp_fire && i_disp_valid_1) begin
                r_valid[w_tail_idx]    <= 1'b1;
                r_addr_rdy[w_tail_idx] <= 1'b0;
                r_issued[w_tail_idx]   <= 1'b0;
                r_wrap[w_tail_idx]     <= r_tail[LQ_SEL];
                r_rob[w_tail_idx]      <= i_disp_rob_idx_1;
                r_base[w_tail_idx]     <= i_disp_base_reg_1;
                r_off[w_tail_idx]      <= i_disp_offset_1;
            end
            if (w_disp_fire && i_disp_valid_2) begin
                r_valid[w_way2_idx]    <= 1'b1;
                r_addr_rdy[w_way2_idx] <= 1'b0;
                r_issued[w_way2_idx]   <= 1'b0;
                r_wrap[w_way2_idx]     <= o_disp_ptr_2[LQ_SEL];
                r_rob[w_way2_idx]      <= i_disp_rob_idx_2;
                r_base[w_way2_idx]     <= i_disp_base_reg_2;
                r_off[w_way2_idx]      <= i_disp_offset_2;
            end
            r_head     <= r_head + PW'(i_commit_cnt);
            r_tail     <= i_flush_valid ? i_flush_ptr : r_tail + w_alloc;
            r_hold     <= w_issue_valid & ~i_issue_ready & ~i_flush_valid;
            r_hold_idx <= w_sel_idx;
        end
    end
endmodule

// File: tb/tb_load_queue_ooo.sv
// Self-checking bench for load_queue_ooo: directed scenarios, then random traffic
// checked against an ordered-list reference model of the queue.
module tb_load_queue_ooo;
    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        dv1, dv2;
    logic [5:0]  rob1, rob2, base1, base2;
    logic [31:0] off1, off2;
    logic        disp_ready;
    logic [3:0]  dptr1, dptr2;
    logic        agu_valid;
    logic [3:0]  agu_ptr;
    logic [31:0] agu_addr;
    logic        issue_valid, issue_ready;
    logic [3:0]  issue_ptr;
    logic [31:0] issue_addr;
    logic [5:0]  issue_rob;
    logic [1:0]  commit_cnt;
    logic        flush_valid;
    logic [3:0]  flush_ptr;
    logic        lq_full, lq_empty;
    logic [3:0]  lq_count;

    always #5 clk = ~clk;

    load_queue_ooo dut (
        .i_clk(clk), .i_reset(rst),
        .i_disp_valid_1(dv1), .i_disp_valid_2(dv2),
        .i_disp_rob_idx_1(rob1), .i_disp_rob_idx_2(rob2),
        .i_disp_base_reg_1(base1), .i_disp_base_reg_2(base2),
        .i_disp_offset_1(off1), .i_disp_offset_2(off2),
        .o_disp_ready(disp_ready), .o_disp_ptr_1(dptr1), .o_disp_ptr_2(dptr2),
        .i_agu_valid(agu_valid), .i_agu_ptr(agu_ptr), .i_agu_addr(agu_addr),
        .o_issue_valid(issue_valid), .i_issue_ready(issue_ready),
        .o_issue_ptr(issue_ptr), .o_issue_addr(issue_addr), .o_issue_rob_idx(issue_rob),
        .i_commit_cnt(commit_cnt), .i_flush_valid(flush_valid), .i_flush_ptr(flush_ptr),
        .o_lq_full(lq_full), .o_lq_empty(lq_empty), .o_lq_count(lq_count)
    );

    typedef struct {
        logic [3:0]  ptr;
        logic [5:0]  rob;
        logic [31:0] addr;
        bit          rdy;
        bit          iss;
    } ent_t;

    ent_t        q[$];
    logic [3:0]  m_head, m_tail, m_hold_ptr;
    bit          m_hold;
    bit          e_iv;
    int          e_pos;
    logic [3:0]  e_ptr;
    logic [31:0] e_addr;
    logic [5:0]  e_rob;
    int          n_assert = 0;
    int          n_fail = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        q.delete();
        m_head = '0;
        m_tail = '0;
        m_hold = 0;
        m_hold_ptr = '0;
    endfunction

    // Expected offer: a refused offer stays pinned, otherwise the oldest address-ready unissued load.
    function automatic void model_issue();
        e_iv = 0; e_pos = -1; e_ptr = '0; e_addr = '0; e_rob = '0;
        if (m_hold)
            foreach (q[i]) if (q[i].ptr == m_hold_ptr && q[i].rdy && !q[i].iss) e_pos = i;
        if (e_pos < 0)
            for (int i = 0; i < q.size(); i++)
                if (q[i].rdy && !q[i].iss) begin e_pos = i; break; end
        if (e_pos >= 0) begin
            e_iv = 1; e_ptr = q[e_pos].ptr; e_addr = q[e_pos].addr; e_rob = q[e_pos].rob;
        end
`ifdef LQ_ISSUE_BYPASS_EN
        else if (agu_valid) begin
            foreach (q[i]) if (q[i].ptr == agu_ptr && !q[i].iss) begin
                e_iv = 1; e_pos = i; e_ptr = q[i].ptr; e_addr = agu_addr; e_rob = q[i].rob;
            end
        end
`endif
    endfunction

    function automatic void model_edge();
        bit         dr;
        logic [3:0] keep;
        dr = (D - q.size()) >= 2;
        if (agu_valid)
            foreach (q[i]) if (q[i].ptr == agu_ptr) begin q[i].addr = agu_addr; q[i].rdy = 1; end
        if (e_iv && issue_ready) begin q[e_pos].iss = 1; q[e_pos].rdy = 1; end
        m_hold = e_iv && !issue_ready && !flush_valid;
        m_hold_ptr = e_ptr;
        for (int i = 0; i < int'(commit_cnt); i++) void'(q.pop_front());
        m_head = m_head + 4'(commit_cnt);
        if (flush_valid) begin
            keep = flush_ptr - m_head;
            while (q.size() > int'(keep)) void'(q.pop_back());
            m_tail = flush_ptr;
        end else if (dr) begin
            if (dv1) begin q.push_back('{m_tail, rob1, 32'h0, 0, 0}); m_tail = m_tail + 4'd1; end
            if (dv2) begin q.push_back('{m_tail, rob2, 32'h0, 0, 0}); m_tail = m_tail + 4'd1; end
        end
    endfunction

    task automatic idle();
        dv1 = 0; dv2 = 0; rob1 = '0; rob2 = '0; base1 = '0; base2 = '0; off1 = '0; off2 = '0;
        agu_valid = 0; agu_ptr = '0; agu_addr = '0; issue_ready = 0;
        commit_cnt = '0; flush_valid = 0; flush_ptr = '0;
    endtask

    // Inputs are set at the falling edge; outputs are checked 1 time unit later, then the model advances.
    task automatic cycle();
        logic [3:0] exp_p2;
        #1;
        model_issue();
        exp_p2 = dv1 ? m_tail + 4'd1 : m_tail;
        chk("lq_count", lq_count, q.size());
        chk("lq_full", lq_full, q.size() == D);
        chk("lq_empty", lq_empty, q.size() == 0);
        chk("disp_ready", disp_ready, (D - q.size()) >= 2);
        chk("disp_ptr_1", dptr1, m_tail);
        chk("disp_ptr_2", dptr2, exp_p2);
        chk("issue_valid", issue_valid, e_iv);
        if (e_iv) begin
            chk("issue_ptr", issue_ptr, e_ptr);
            chk("issue_addr", issue_addr, e_addr);
            chk("issue_rob", issue_rob, e_rob);
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk);
        m_reset();
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        int   idxs[$];
        int   lead, mx, pick;
        rst = 1;
        idle();
        m_reset();
        #12;
        dv1 = 1;
        #1;
        chk("rst_count", lq_count, 0);
        chk("rst_empty", lq_empty, 1);
        chk("rst_full", lq_full, 0);
        chk("rst_disp_ready", disp_ready, 1);
        chk("rst_ptr1", dptr1, 0);
        chk("rst_ptr2", dptr2, 1);
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_issue_addr", issue_addr, 0);
        chk("rst_issue_ptr", issue_ptr, 0);
        chk("rst_issue_rob", issue_rob, 0);
        idle();
        @(negedge clk);
        rst = 0;

        // dual dispatch ROB 3/4
        dv1 = 1; dv2 = 1; rob1 = 6'd3; rob2 = 6'd4;
        #1;
        chk("dd_ptr1", dptr1, 0);
        chk("dd_ptr2", dptr2, 1);
        cycle();
        idle();
        #1;
        chk("dd_count", lq_count, 2);
        chk("dd_issue_valid", issue_valid, 0);

        // out-of-order address arrival, stalled handshake
        agu_valid = 1; agu_ptr = 4'd1; agu_addr = 32'h100;
        cycle();
        idle(); agu_valid = 1; agu_ptr = 4'd0; agu_addr = 32'h200;
        #1;
        chk("ooo_first_ptr", issue_ptr, 1);
        chk("ooo_first_addr", issue_addr, 32'h100);
        cycle();
        idle();
        #1;
        chk("hold_ptr", issue_ptr, 1);
        chk("hold_addr", issue_addr, 32'h100);
        chk("hold_rob", issue_rob, 4);
        cycle();
        idle(); issue_ready = 1;
        cycle();
        idle(); issue_ready = 1;
        #1;
        chk("second_ptr", issue_ptr, 0);
        chk("second_addr", issue_addr, 32'h200);
        cycle();
        idle(); commit_cnt = 2'd2;
        cycle();

        // fill to full
        for (int i = 0; i < 4; i++) begin
            idle(); dv1 = 1; dv2 = 1; rob1 = 6'(10 + 2 * i); rob2 = 6'(11 + 2 * i);
            cycle();
        end
        idle();
        #1;
        chk("fill_full", lq_full, 1);
        chk("fill_disp_ready", disp_ready, 0);
        for (int i = 0; i < 10; i++) begin
            idle(); issue_ready = 1;
            if (i < 8) begin agu_valid = 1; agu_ptr = 4'(2 + i); agu_addr = 32'h1000 + 32'(i); end
            cycle();
        end
        idle(); commit_cnt = 2'd2; cycle();
        idle(); commit_cnt = 2'd2; cycle();
        idle(); dv1 = 1; dv2 = 1; rob1 = 6'd20; rob2 = 6'd21;
        #1;
        chk("wrap_ptr1", dptr1, 4'hA);
        chk("wrap_ptr2", dptr2, 4'hB);
        cycle();
        idle(); dv1 = 1; rob1 = 6'd22; cycle();
        idle();
        #1;
        chk("cnt7_disp_ready", disp_ready, 0);
        dv1 = 1; dv2 = 1;
        cycle();
        chk("cnt7_dropped", lq_count, 7);

        // reset mid-operation
        idle();
        rst = 1;
        #1;
        chk("midrst_count", lq_count, 0);
        @(posedge clk);
        m_reset();
        @(negedge clk);
        rst = 0;

        // flush with concurrent dispatch and AGU to a flushed entry
        for (int i = 0; i < 3; i++) begin
            idle(); dv1 = 1; dv2 = 1; rob1 = 6'(30 + 2 * i); rob2 = 6'(31 + 2 * i);
            cycle();
        end
        idle(); dv1 = 1; dv2 = 1; flush_valid = 1; flush_ptr = 4'd3;
        agu_valid = 1; agu_ptr = 4'd4; agu_addr = 32'hDEAD;
        cycle();
        idle();
        #1;
        chk("flush_count", lq_count, 3);
        chk("flush_tail", dptr1, 3);
        dv1 = 1; dv2 = 1; rob1 = 6'd40; rob2 = 6'd41;
        cycle();
        idle();
        #1;
        chk("flush_agu_dropped", issue_valid, 0);
        cycle();

        // commit and dispatch together at count 5
        idle(); issue_ready = 1; agu_valid = 1; agu_ptr = 4'd0; agu_addr = 32'h300; cycle();
        idle(); issue_ready = 1; agu_valid = 1; agu_ptr = 4'd1; agu_addr = 32'h304; cycle();
        idle(); issue_ready = 1; cycle();
        idle(); commit_cnt = 2'd2; dv1 = 1; dv2 = 1; rob1 = 6'd42; rob2 = 6'd43;
        cycle();
        idle();
        #1;
        chk("cd_count", lq_count, 5);
        chk("cd_tail", dptr1, 7);

        // AGU-to-issue latency
        do_reset();
        idle(); dv1 = 1; rob1 = 6'd9; cycle();
        idle(); agu_valid = 1; agu_ptr = 4'd0; agu_addr = 32'h40; issue_ready = 1;
        #1;
`ifdef LQ_ISSUE_BYPASS_EN
        chk("byp_valid", issue_valid, 1);
        chk("byp_addr", issue_addr, 32'h40);
`else
        chk("nobyp_valid", issue_valid, 0);
`endif
        cycle();
        idle(); issue_ready = 1;
        #1;
`ifdef LQ_ISSUE_BYPASS_EN
        chk("byp_next_valid", issue_valid, 0);
`else
        chk("nobyp_next_valid", issue_valid, 1);
        chk("nobyp_next_addr", issue_addr, 32'h40);
`endif
        cycle();

        // random traffic
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            idle();
            dv1 = 1'($urandom_range(0, 1));
            dv2 = 1'($urandom_range(0, 1));
            rob1 = 6'($urandom); rob2 = 6'($urandom);
            base1 = 6'($urandom); base2 = 6'($urandom);
            off1 = $urandom; off2 = $urandom;
            issue_ready = ($urandom_range(0, 3) != 0);
            pick = $urandom_range(0, 9);
            idxs.delete();
            foreach (q[i]) if (!q[i].rdy) idxs.push_back(i);
            if (pick < 6 && idxs.size() > 0) begin
                agu_valid = 1;
                agu_ptr = q[idxs[$urandom_range(0, idxs.size() - 1)]].ptr;
                agu_addr = $urandom;
            end else if (pick == 6 && q.size() > 0 && q.size() < D) begin
                agu_valid = 1;
                agu_ptr = m_head ^ 4'h8;
                agu_addr = $urandom;
            end
            lead = 0;
            while (lead < q.size() && q[lead].iss) lead++;
            mx = (lead < 2) ? lead : 2;
            commit_cnt = 2'($urandom_range(0, mx));
            if ($urandom_range(0, 11) == 0) begin
                flush_valid = 1;
                flush_ptr = m_head + 4'(commit_cnt) + 4'($urandom_range(0, q.size() - int'(commit_cnt)));
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
